// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory store buffer.
package dmem_pkg;

    typedef struct packed {
        logic        valid;
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  strb;
    } sb_entry_t;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } sb_state_t;

    // Per byte lane: take upd where sel is set, otherwise keep base.
    function automatic logic [31:0] lane_merge(input logic [31:0] base,
                                               input logic [31:0] upd,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = sel[i] ? upd[i*8 +: 8] : base[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_store_buffer_sb_fifo.sv
// Circular store-buffer storage; all entries are exposed for load forwarding.
module sb_fifo
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  sb_entry_t                  i_push_entry,
    input  logic                       i_merge,
    input  logic [31:0]                i_merge_data,
    input  logic [3:0]                 i_merge_strb,
    input  logic                       i_pop,
    output sb_entry_t                  o_entries [DEPTH],
    output logic [$clog2(DEPTH)-1:0]   o_head,
    output logic [$clog2(DEPTH)-1:0]   o_tail,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;
    logic [PW-1:0] w_last;

    assign w_last = r_tail - 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            sb_entry_t r_ent;
            // Push and pop never target the same slot: that would need a buffer both empty and full.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ent <= '0;
                end else if (i_push && r_tail == PW'(gi)) begin
                    r_ent       <= i_push_entry;
                    r_ent.valid <= 1'b1;
                end else if (i_merge && w_last == PW'(gi)) begin
                    r_ent.data <= lane_merge(r_ent.data, i_merge_data, i_merge_strb);
                    r_ent.strb <= r_ent.strb | i_merge_strb;
                end else if (i_pop && r_head == PW'(gi)) begin
                    r_ent.valid <= 1'b0;
                end
            end
            assign o_entries[gi] = r_ent;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= r_tail + 1'b1;
            if (i_pop)  r_head <= r_head + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_tail  = r_tail;
    assign o_count = r_count;

endmodule

// File: rtl/dmem_store_buffer.sv
// Arbitrates core load/store onto one SRAM port with a forwarding store buffer.
// Define DMEM_COALESCE_EN to merge stores into the youngest entry of the same word.
module dmem_store_buffer
    import dmem_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_re,
    input  logic [31:0] core_raddr,
    output logic [31:0] core_rdata,
    input  logic        core_we,
    input  logic [31:0] core_waddr,
    input  logic [31:0] core_wdata,
    input  logic [3:0]  core_wstrb,
    output logic        core_stall,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [29:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        sb_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    sb_entry_t     w_entries [DEPTH];
    sb_entry_t     w_head_ent;
    sb_entry_t     w_push_entry;
    logic [PW-1:0] w_head;
    logic [PW-1:0] w_tail;
    logic [PW:0]   w_count;

    sb_state_t     r_state;
    logic [SW-1:0] r_starve;
    logic          r_rvalid;
    logic [31:0]   r_fwd_data;
    logic [3:0]    r_fwd_mask;

    logic          w_full;
    logic          w_drain;
    logic          w_read_grant;
    logic          w_coal_hit;
    logic          w_stall;
    logic          w_wr_accept;
    logic          w_rd_accept;
    logic          w_push;
    logic          w_merge;
    logic [31:0]   w_fwd_data;
    logic [3:0]    w_fwd_mask;
    logic          w_unused_bits;

    assign w_unused_bits = ^{core_raddr[1:0], core_waddr[1:0], w_tail};

    assign w_full     = (w_count == (PW+1)'(DEPTH));
    assign w_head_ent = w_entries[w_head];

    // The port belongs to the load in NORMAL even when the request is stalled by a full buffer.
    assign w_drain      = !rst && (w_count != '0) && (r_state == FORCE || !core_re);
    assign w_read_grant = !rst && core_re && (r_state == NORMAL);

`ifdef DMEM_COALESCE_EN
    logic [PW-1:0] w_last;
    sb_entry_t     w_youngest;
    assign w_last     = w_tail - 1'b1;
    assign w_youngest = w_entries[w_last];
    assign w_coal_hit = core_we && w_youngest.valid
                        && (w_youngest.waddr == core_waddr[31:2])
                        && !(w_drain && w_count == (PW+1)'(1));
`else
    assign w_coal_hit = 1'b0;
`endif

    assign w_stall     = !rst && ((core_we && w_full && !w_coal_hit) ||
                                  (core_re && r_state == FORCE));
    assign w_wr_accept = !rst && core_we && !w_stall;
    assign w_rd_accept = w_read_grant && !w_stall;
    assign w_push      = w_wr_accept && !w_coal_hit;
    assign w_merge     = w_wr_accept && w_coal_hit;

    assign w_push_entry = '{valid: 1'b1, waddr: core_waddr[31:2],
                            data: core_wdata, strb: core_wstrb};

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_merge      (w_merge),
        .i_merge_data (core_wdata),
        .i_merge_strb (core_wstrb),
        .i_pop        (w_drain),
        .o_entries    (w_entries),
        .o_head       (w_head),
        .o_tail       (w_tail),
        .o_count      (w_count)
    );

    // Walk oldest to youngest so younger stores overwrite older lanes; the same-cycle store is youngest.
    always_comb begin
        w_fwd_data = '0;
        w_fwd_mask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            logic [PW-1:0] idx;
            idx = w_head + PW'(k);
            if (w_entries[idx].valid && w_entries[idx].waddr == core_raddr[31:2]) begin
                w_fwd_data = lane_merge(w_fwd_data, w_entries[idx].data, w_entries[idx].strb);
                w_fwd_mask = w_fwd_mask | w_entries[idx].strb;
            end
        end
        if (w_wr_accept && core_waddr[31:2] == core_raddr[31:2]) begin
            w_fwd_data = lane_merge(w_fwd_data, core_wdata, core_wstrb);
            w_fwd_mask = w_fwd_mask | core_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid   <= 1'b0;
            r_fwd_data <= '0;
            r_fwd_mask <= '0;
        end else begin
            r_rvalid <= w_rd_accept;
            if (w_rd_accept) begin
                r_fwd_data <= w_fwd_data;
                r_fwd_mask <= w_fwd_mask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= NORMAL;
            r_starve <= '0;
        end else begin
            case (r_state)
                NORMAL: begin
                    if (core_re && w_count != '0) begin
                        if (r_starve == SW'(STARVE_LIMIT - 1)) begin
                            r_state  <= FORCE;
                            r_starve <= SW'(STARVE_LIMIT);
                        end else begin
                            r_starve <= r_starve + 1'b1;
                        end
                    end else begin
                        r_starve <= '0;
                    end
                end
                FORCE: begin
                    r_state  <= NORMAL;
                    r_starve <= '0;
                end
                default: begin
                    r_state  <= NORMAL;
                    r_starve <= '0;
                end
            endcase
        end
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 4'h0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (w_drain) begin
            ram_en    = 1'b1;
            ram_we    = w_head_ent.strb;
            ram_addr  = w_head_ent.waddr;
            ram_wdata = w_head_ent.data;
        end else if (w_read_grant) begin
            ram_en   = 1'b1;
            ram_addr = core_raddr[31:2];
        end
    end

    assign core_rdata = (r_rvalid && !rst) ? lane_merge(ram_rdata, r_fwd_data, r_fwd_mask) : '0;
    assign core_stall = w_stall;
    assign sb_empty   = rst || (w_count == '0);

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Randomised and directed bench for dmem_store_buffer against a program-order memory model.
module tb_dmem_store_buffer;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_re;
    logic [31:0] core_raddr;
    logic [31:0] core_rdata;
    logic        core_we;
    logic [31:0] core_waddr;
    logic [31:0] core_wdata;
    logic [3:0]  core_wstrb;
    logic        core_stall;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [29:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;
    logic        sb_empty;

    dmem_store_buffer #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .core_re(core_re), .core_raddr(core_raddr), .core_rdata(core_rdata),
        .core_we(core_we), .core_waddr(core_waddr), .core_wdata(core_wdata),
        .core_wstrb(core_wstrb), .core_stall(core_stall),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .sb_empty(sb_empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // SRAM contents as the bench's SRAM sees them, and memory as the program expects it.
    logic [31:0] sram [bit [29:0]];
    logic [31:0] arch [bit [29:0]];
    int          sram_writes = 0;

    typedef struct {
        bit [29:0] a;
        bit [31:0] d;
        bit [3:0]  s;
    } ent_t;
    ent_t q[$];
    bit        m_force = 0;
    int        starve = 0;
    bit        rd_pending = 0;
    bit [31:0] exp_rdata;

    logic        s_en, s_stall, s_empty;
    logic [3:0]  s_we;
    logic [29:0] s_addr;
    logic [31:0] s_wd, last_rdata;

    logic        c_en;
    logic [3:0]  c_we;
    logic [29:0] c_addr;
    logic [31:0] c_wd;

    function automatic logic [31:0] sram_rd(input bit [29:0] a);
        return sram.exists(a) ? sram[a] : 32'h0;
    endfunction

    function automatic logic [31:0] arch_rd(input bit [29:0] a);
        return arch.exists(a) ? arch[a] : 32'h0;
    endfunction

    function automatic bit [31:0] put_bytes(input bit [31:0] old, input bit [31:0] nw, input bit [3:0] s);
        bit [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    always @(negedge clk) begin
        #2;
        c_en = ram_en; c_we = ram_we; c_addr = ram_addr; c_wd = ram_wdata;
    end

    always @(posedge clk) begin
        if (c_en) begin
            ram_rdata <= sram_rd(c_addr);
            if (c_we != 4'h0) begin
                sram[c_addr] = put_bytes(sram_rd(c_addr), c_wd, c_we);
                sram_writes++;
            end
        end
    end

    task automatic step(input bit re, input bit [31:0] ra, input bit we, input bit [31:0] wa,
                        input bit [31:0] wd, input bit [3:0] ws, output bit stalled);
        int sz;
        bit coal, drain, exp_stall, exp_en;
        bit [3:0] exp_we;
        bit [29:0] exp_addr;
        @(negedge clk);
        rst = 0; core_re = re; core_raddr = ra; core_we = we;
        core_waddr = wa; core_wdata = wd; core_wstrb = ws;
        #1;
        s_en = ram_en; s_we = ram_we; s_addr = ram_addr; s_wd = ram_wdata;
        s_stall = core_stall; s_empty = sb_empty;
        if (rd_pending) begin
            checks++;
            last_rdata = core_rdata;
            if (core_rdata !== exp_rdata) begin
                errors++;
                $display("FAIL load_data got %h want %h", core_rdata, exp_rdata);
            end
        end
        sz = q.size();
        drain = (sz > 0) && (m_force || !re);
        coal = 0;
`ifdef DMEM_COALESCE_EN
        if (we && sz > 0 && q[sz-1].a == wa[31:2] && !(drain && sz == 1)) coal = 1;
`endif
        exp_stall = (we && sz == DEPTH && !coal) || (re && m_force);
        exp_en    = drain || (re && !m_force);
        exp_we    = drain ? q[0].s : 4'h0;
        exp_addr  = drain ? q[0].a : ra[31:2];
        checks += 4;
        if (core_stall !== exp_stall) begin errors++; $display("FAIL stall got %b want %b", core_stall, exp_stall); end
        if (ram_en !== exp_en) begin errors++; $display("FAIL ram_en got %b want %b", ram_en, exp_en); end
        if (ram_we !== exp_we) begin errors++; $display("FAIL ram_we got %h want %h", ram_we, exp_we); end
        if (sb_empty !== (sz == 0)) begin errors++; $display("FAIL sb_empty got %b want %b", sb_empty, sz == 0); end
        if (exp_en) begin
            checks++;
            if (ram_addr !== exp_addr) begin errors++; $display("FAIL ram_addr got %h want %h", ram_addr, exp_addr); end
        end
        if (drain) begin
            checks++;
            if (ram_wdata !== q[0].d) begin errors++; $display("FAIL ram_wdata got %h want %h", ram_wdata, q[0].d); end
            void'(q.pop_front());
        end
        stalled = exp_stall;
        if (!exp_stall && we) begin
            arch[wa[31:2]] = put_bytes(arch_rd(wa[31:2]), wd, ws);
            if (coal) begin
                q[q.size()-1].d = put_bytes(q[q.size()-1].d, wd, ws);
                q[q.size()-1].s = q[q.size()-1].s | ws;
            end else begin
                q.push_back('{a: wa[31:2], d: wd, s: ws});
            end
        end
        rd_pending = 0;
        if (!exp_stall && re) begin
            exp_rdata  = arch_rd(ra[31:2]);
            rd_pending = 1;
        end
        if (m_force) begin
            m_force = 0; starve = 0;
        end else if (re && sz > 0) begin
            starve++;
            if (starve == LIMIT) m_force = 1;
        end else begin
            starve = 0;
        end
    endtask

    task automatic idle(input int n);
        bit st;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, st);
    endtask

    task automatic drain_all();
        int guard = 0;
        while (q.size() > 0 && guard < 20) begin idle(1); guard++; end
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL drain_timeout left %0d want 0", q.size()); end
        idle(1);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1; core_re = 1; core_raddr = 32'h100; core_we = 1;
        core_waddr = 32'h100; core_wdata = 32'hDEADBEEF; core_wstrb = 4'hF;
        for (int i = 0; i <= n; i++) begin
            if (i == n) begin
                @(negedge clk);
                rst = 0; core_re = 0; core_we = 0;
            end
            #1;
            checks += 5;
            if (ram_en !== 1'b0) begin errors++; $display("FAIL rst_ram_en got %b want 0", ram_en); end
            if (ram_we !== 4'h0) begin errors++; $display("FAIL rst_ram_we got %h want 0", ram_we); end
            if (core_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", core_rdata); end
            if (core_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", core_stall); end
            if (sb_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b want 1", sb_empty); end
            if (i < n) @(negedge clk);
        end
        q.delete(); m_force = 0; starve = 0; rd_pending = 0;
        arch = sram;
    endtask

    task automatic test_reset();
        do_reset(2);
        $display("test_reset done");
    endtask

    task automatic test_drain_basic();
        bit st;
        step(0, 0, 1, 32'h100, 32'h11223344, 4'hF, st);
        step(0, 0, 0, 0, 0, 0, st);
        checks++;
        if (s_we !== 4'hF || s_addr !== 30'h40 || s_wd !== 32'h11223344) begin
            errors++; $display("FAIL drain_basic got we=%h addr=%h wd=%h want F/40/11223344", s_we, s_addr, s_wd);
        end
        idle(1);
        checks++;
        if (s_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", s_empty); end
        $display("test_drain_basic done");
    endtask

    task automatic test_forward_partial();
        bit st;
        sram[30'h80] = 32'h55667788; arch[30'h80] = 32'h55667788;
        step(0, 0, 1, 32'h200, 32'hAABBCCDD, 4'b0011, st);
        step(1, 32'h200, 0, 0, 0, 0, st);
        step(0, 0, 0, 0, 0, 0, st);
        checks++;
        if (last_rdata !== 32'h5566CCDD) begin errors++; $display("FAIL fwd_partial got %h want 5566CCDD", last_rdata); end
        drain_all();
        $display("test_forward_partial done");
    endtask

    task automatic test_same_cycle();
        bit st;
        sram[30'hC0] = 32'h12345678; arch[30'hC0] = 32'h12345678;
        step(1, 32'h300, 1, 32'h300, 32'h000000EE, 4'b0001, st);
        checks++;
        if (s_stall !== 1'b0) begin errors++; $display("FAIL same_cycle_stall got %b want 0", s_stall); end
        step(0, 0, 0, 0, 0, 0, st);
        checks++;
        if (last_rdata !== 32'h123456EE) begin errors++; $display("FAIL same_cycle got %h want 123456EE", last_rdata); end
        drain_all();
        $display("test_same_cycle done");
    endtask

    task automatic test_full_force();
        bit st;
        int stalls = 0;
        for (int i = 0; i < DEPTH; i++)
            step(1, 32'h400, 1, 32'h400 + 32'(i*4), 32'hA0A0A0A0 + 32'(i), 4'hF, st);
        step(1, 32'h400, 1, 32'h420, 32'h5555AAAA, 4'hF, st);
        checks++;
        if (s_stall !== 1'b1) begin errors++; $display("FAIL full_stall got %b want 1", s_stall); end
        while (st && stalls < 30) begin
            stalls++;
            step(1, 32'h400, 1, 32'h420, 32'h5555AAAA, 4'hF, st);
        end
        checks++;
        if (stalls != LIMIT - DEPTH + 2) begin
            errors++; $display("FAIL full_force_stalls got %0d want %0d", stalls, LIMIT - DEPTH + 2);
        end
        drain_all();
        $display("test_full_force done");
    endtask

    task automatic test_starve();
        bit st = 0;
        int loads = 0;
        step(0, 0, 1, 32'h500, 32'hCAFEF00D, 4'b0110, st);
        step(1, 32'h504, 0, 0, 0, 0, st);
        while (!st && loads < 20) begin
            loads++;
            step(1, 32'h504, 0, 0, 0, 0, st);
        end
        checks += 2;
        if (loads != LIMIT) begin errors++; $display("FAIL starve_loads got %0d want %0d", loads, LIMIT); end
        if (s_we !== 4'b0110) begin errors++; $display("FAIL force_drain_we got %h want 6", s_we); end
        step(1, 32'h500, 0, 0, 0, 0, st);
        checks++;
        if (s_stall !== 1'b0 || s_empty !== 1'b1) begin
            errors++; $display("FAIL starve_resume got stall=%b empty=%b want 0/1", s_stall, s_empty);
        end
        idle(2);
        $display("test_starve done");
    endtask

    task automatic test_reset_mid();
        bit st;
        int wr_before;
        for (int i = 0; i < 3; i++)
            step(1, 32'h600, 1, 32'h600 + 32'(i*4), 32'h77777777, 4'hF, st);
        wr_before = sram_writes;
        do_reset(1);
        idle(5);
        checks += 2;
        if (sram_writes != wr_before) begin errors++; $display("FAIL reset_mid_writes got %0d want %0d", sram_writes, wr_before); end
        if (s_empty !== 1'b1) begin errors++; $display("FAIL reset_mid_empty got %b want 1", s_empty); end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        bit st = 0;
        bit re, we;
        bit [31:0] ra, wa, wd;
        bit [3:0] ws;
        for (int n = 0; n < 1500; n++) begin
            if (!st) begin
                re = ($urandom_range(0, 9) < 6);
                we = ($urandom_range(0, 9) < 5);
                ra = 32'h1000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
                wa = 32'h1000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
                wd = $urandom;
                ws = 4'($urandom_range(1, 15));
            end
            step(re, ra, we, wa, wd, ws, st);
        end
        drain_all();
        for (int w = 0; w < 8; w++) begin
            checks++;
            if (sram_rd(30'h400 + 30'(w)) !== arch_rd(30'h400 + 30'(w))) begin
                errors++;
                $display("FAIL final_mem[%0d] got %h want %h", w, sram_rd(30'h400 + 30'(w)), arch_rd(30'h400 + 30'(w)));
            end
        end
        $display("test_random done");
    endtask

    initial begin
        rst = 1; core_re = 0; core_raddr = 0; core_we = 0;
        core_waddr = 0; core_wdata = 0; core_wstrb = 0;
        test_reset();
        test_drain_basic();
        test_forward_partial();
        test_same_cycle();
        test_full_force();
        test_starve();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
